pin_deserializer: RTL and testbench
===================================

Name: pin_deserializer

Overview:
- Receive-side counterpart of the pin-array test block, which collapses a 4-bit `vin` bus onto a single `vout` pin.
- Reassembles a framed serial bit stream on one pin into a WIDTH-bit parallel word.
- Presents each completed word on a valid/ready holding register.
- Flags overruns and framing errors. Sits at the pad-array boundary, feeding digital test logic.

Parameters:
- WIDTH, 4: bits per word; legal range 2..16.
- MSB_FIRST, 0: 0 = first received bit lands in `vout[0]`; 1 = first bit lands in `vout[WIDTH-1]`.
- CONTINUOUS, 0: 0 = return to IDLE after each word, so a new sof is required; 1 = keep shifting back-to-back words after one sof.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- VDD  input  1  supply pin, no logic function.
- VSS  input  1  ground pin, no logic function.
- vin  input  1  serial data bit.
- vin_valid  input  1  `vin` is sampled this cycle.
- vin_sof  input  1  start of frame; qualified by `vin_valid`; marks the current bit as bit 0.
- vout  output  WIDTH  assembled word (holding register).
- vout_valid  output  1  `vout` holds an unconsumed word.
- vout_ready  input  1  consumer accepts `vout` this cycle.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: sof arrived mid-word.
- clr_err  input  1  synchronous clear of `overrun` and `frame_err`.
- busy  output  1  state is SHIFT.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: `vout` = 0, `vout_valid` = 0, `overrun` = 0, `frame_err` = 0, `busy` = 0. State = IDLE, bit counter = 0, shift register = 0.
- Reset asserted mid-word or with a word pending discards everything immediately. No output pulse on deassert.
- VDD and VSS are unused by logic.
- States: IDLE and SHIFT.
- IDLE:
  - `vin_valid` without `vin_sof` is ignored.
  - `vin_valid` with `vin_sof`: capture `vin` as bit 0, counter = 1, go to SHIFT.
- SHIFT:
  - Each `vin_valid` captures `vin` at index = counter (LSB-first) or WIDTH-1-counter (MSB_FIRST), then increments the counter.
  - Cycles without `vin_valid` hold state; there is no timeout.
- Word completion: `vin_valid` arrives while counter = WIDTH-1.
  - The word, including this bit, is complete on that edge.
  - Counter returns to 0.
  - Next state is IDLE if CONTINUOUS = 0, otherwise SHIFT.
  - WIDTH = 2 with sof completes on the second valid bit.
- SOF inside SHIFT with counter ≠ 0:
  - Partial word discarded; `frame_err` set.
  - Current bit becomes bit 0 of a new word; counter = 1; stay in SHIFT.
  - If counter = 0 (CONTINUOUS word boundary), sof is legal and no error is raised.
- Output register:
  - A word completing at edge N drives `vout_valid` = 1 and `vout` = word after edge N. Latency is 1 cycle from the last bit's sample edge.
  - Handshake fires when `vout_valid && vout_ready`; `vout_valid` drops next cycle unless a new word loads on the same edge.
  - `vout` and `vout_valid` stay stable while `vout_valid && !vout_ready`.
- Simultaneous completion and handshake: the new word loads and `vout_valid` stays 1 (no bubble).
- Completion while `vout_valid && !vout_ready`: the new word is dropped, the old word is kept, `overrun` is set.
- Sticky errors:
  - `clr_err` clears both flags.
  - If `clr_err` and a new error event occur on the same edge, the flag is set (set wins).
- `busy` = (state == SHIFT).

Test Plan:
- WIDTH=4, LSB-first, CONTINUOUS=0: sof with bits 1,0,1,1 on consecutive cycles, `vout_ready` = 1 → one cycle after the 4th bit, `vout` = 4'hD and `vout_valid` = 1 for one cycle; state returns to IDLE; busy low.
- MSB_FIRST=1: same bits 1,0,1,1 → `vout` = 4'hB. With `vin_valid` gapped every other cycle → same word, completing 1 cycle after the last valid bit.
- `vout_ready` = 0, CONTINUOUS=1: two words 4'h3 then 4'hA → `vout` holds 4'h3, `overrun` = 1. Then ready = 1 → 4'h3 accepted, `vout_valid` falls. `clr_err` clears `overrun`.
- Back-to-back CONTINUOUS words with ready = 1 and completion on the handshake edge → `vout_valid` stays high, `vout` goes 4'h5 → 4'h6, no overrun.
- sof after 2 bits of a word → `frame_err` = 1; the following 4 bits (first is the sof bit) assemble correctly; no output for the aborted word.
- Assert `rst_n` low mid-word with `vout_valid` = 1 → all outputs 0 immediately. Bits after release without sof are ignored.

Source files
------------

// File: rtl/pin_deserializer.sv
// pin_deserializer: reassembles a framed single-pin serial stream into
// WIDTH-bit words, presented on a valid/ready holding register, with sticky
// overrun and framing-error flags.
module pin_deserializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             VDD,
  input  logic             VSS,
  input  logic             vin,
  input  logic             vin_valid,
  input  logic             vin_sof,
  output logic [WIDTH-1:0] vout,
  output logic             vout_valid,
  input  logic             vout_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] vout_q, vout_d;
  logic             vout_valid_q, vout_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic [WIDTH-1:0] word;
  logic             complete;
  logic             frame_evt;
  logic             overrun_evt;

  // Supply pins carry no logic function; fold them into a sink net.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Merge one received bit into a word at the slot for bit number c,
  // honouring the configured bit order.
  function automatic logic [WIDTH-1:0] put_bit(input logic [WIDTH-1:0] base,
                                               input logic [CW-1:0]    c,
                                               input logic             b);
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] mask;
    idx  = MSB_FIRST ? (LAST - c) : c;
    mask = WIDTH'(1) << idx;
    return (base & ~mask) | (b ? mask : '0);
  endfunction

  // Receive FSM: frame detection, bit placement and word completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word      = shift_q;
    complete  = 1'b0;
    frame_evt = 1'b0;
    if (vin_valid) begin
      if (state_q == ST_IDLE) begin
        if (vin_sof) begin
          shift_d = put_bit('0, '0, vin);
          cnt_d   = CW'(1);
          state_d = ST_SHIFT;
        end
      end else if (vin_sof && (cnt_q != '0)) begin
        // Restart mid-word: the partial word is abandoned.
        frame_evt = 1'b1;
        shift_d   = put_bit('0, '0, vin);
        cnt_d     = CW'(1);
      end else begin
        // A sof at count 0 (continuous word boundary) is simply bit 0.
        word = put_bit(shift_q, cnt_q, vin);
        if (cnt_q == LAST) begin
          complete = 1'b1;
          cnt_d    = '0;
          shift_d  = '0;
          state_d  = CONTINUOUS ? ST_SHIFT : ST_IDLE;
        end else begin
          shift_d = word;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    end
  end

  // Holding register handshake and sticky error flags (set beats clear).
  always_comb begin
    vout_d       = vout_q;
    vout_valid_d = vout_valid_q;
    overrun_evt  = 1'b0;
    if (complete) begin
      if (!vout_valid_q || vout_ready) begin
        vout_d       = word;
        vout_valid_d = 1'b1;
      end else begin
        overrun_evt = 1'b1;
      end
    end else if (vout_valid_q && vout_ready) begin
      vout_valid_d = 1'b0;
    end
    overrun_d   = overrun_evt | (overrun_q & ~clr_err);
    frame_err_d = frame_evt | (frame_err_q & ~clr_err);
  end

  // Receive-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Output-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout_q       <= '0;
      vout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      vout_q       <= vout_d;
      vout_valid_q <= vout_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign vout       = vout_q;
  assign vout_valid = vout_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_pin_deserializer.sv
// Bench for pin_deserializer: three instances (LSB-first, MSB-first,
// LSB-first continuous) with a per-instance expected-word scoreboard.
module tb_pin_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vin_a[3];
  logic vv_in_a[3];
  logic sof_a[3];
  logic rdy_a[3];
  logic clr_a[3];
  logic [3:0] vout_a[3];
  logic vout_valid_a[3];
  logic ov_a[3];
  logic fe_a[3];
  logic busy_a[3];

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pin_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .VDD(1'b1), .VSS(1'b0),
    .vin(vin_a[0]), .vin_valid(vv_in_a[0]), .vin_sof(sof_a[0]),
    .vout(vout_a[0]), .vout_valid(vout_valid_a[0]), .vout_ready(rdy_a[0]),
    .overrun(ov_a[0]), .frame_err(fe_a[0]), .clr_err(clr_a[0]), .busy(busy_a[0]));

  pin_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .VDD(1'b1), .VSS(1'b0),
    .vin(vin_a[1]), .vin_valid(vv_in_a[1]), .vin_sof(sof_a[1]),
    .vout(vout_a[1]), .vout_valid(vout_valid_a[1]), .vout_ready(rdy_a[1]),
    .overrun(ov_a[1]), .frame_err(fe_a[1]), .clr_err(clr_a[1]), .busy(busy_a[1]));

  pin_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0), .CONTINUOUS(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .VDD(1'b1), .VSS(1'b0),
    .vin(vin_a[2]), .vin_valid(vv_in_a[2]), .vin_sof(sof_a[2]),
    .vout(vout_a[2]), .vout_valid(vout_valid_a[2]), .vout_ready(rdy_a[2]),
    .overrun(ov_a[2]), .frame_err(fe_a[2]), .clr_err(clr_a[2]), .busy(busy_a[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [3:0] w);
    case (d)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  // Called when a handshake is about to fire on instance d.
  task automatic pop_chk(input int d);
    logic [3:0] w;
    int sz;
    case (d)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      chk($sformatf("unexpected_word_d%0d", d), {28'd0, vout_a[d]}, 32'hFFFF_FFFF);
    end else begin
      case (d)
        0: w = q0.pop_front();
        1: w = q1.pop_front();
        default: w = q2.pop_front();
      endcase
      $display("word d=%0d vout=%h expected=%h t=%0t", d, vout_a[d], w, $time);
      chk($sformatf("word_d%0d", d), {28'd0, vout_a[d]}, {28'd0, w});
    end
  endtask

  // Handshakes are observed mid-cycle, ahead of the edge that consumes them.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (vout_valid_a[d] && rdy_a[d]) pop_chk(d);
      end
    end
  end

  // Present one bit for one cycle; returns 1 time unit after the sampling edge.
  task automatic send_bit(input int d, input logic b, input logic sof);
    vin_a[d] = b;
    vv_in_a[d] = 1'b1;
    sof_a[d] = sof;
    @(posedge clk);
    #1;
    vv_in_a[d] = 1'b0;
    sof_a[d] = 1'b0;
    vin_a[d] = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int d, input logic [3:0] bits_in_order, input logic sof);
    for (int i = 0; i < 4; i++) send_bit(d, bits_in_order[3-i], (i == 0) ? sof : 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      vin_a[d] = 1'b0; vv_in_a[d] = 1'b0; sof_a[d] = 1'b0;
      rdy_a[d] = 1'b0; clr_a[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle();

    // Reset state
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_vout_d%0d", d), {28'd0, vout_a[d]}, 32'd0);
      chk($sformatf("rst_valid_d%0d", d), {31'd0, vout_valid_a[d]}, 32'd0);
      chk($sformatf("rst_busy_d%0d", d), {31'd0, busy_a[d]}, 32'd0);
      chk($sformatf("rst_err_d%0d", d), {30'd0, ov_a[d], fe_a[d]}, 32'd0);
    end

    // LSB-first single word, bits 1,0,1,1 -> D
    rdy_a[0] = 1'b1;
    push_exp(0, 4'hD);
    send_bit(0, 1'b1, 1'b1);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    chk("t1_valid_before_last", {31'd0, vout_valid_a[0]}, 32'd0);
    chk("t1_busy_mid", {31'd0, busy_a[0]}, 32'd1);
    send_bit(0, 1'b1, 1'b0);
    chk("t1_valid", {31'd0, vout_valid_a[0]}, 32'd1);
    chk("t1_vout", {28'd0, vout_a[0]}, 32'hD);
    chk("t1_busy_idle", {31'd0, busy_a[0]}, 32'd0);
    idle_cycle();
    chk("t1_valid_drop", {31'd0, vout_valid_a[0]}, 32'd0);

    // MSB-first, contiguous then gapped, bits 1,0,1,1 -> B
    rdy_a[1] = 1'b1;
    push_exp(1, 4'hB);
    send_word(1, 4'b1011, 1'b1);
    chk("t2_vout", {28'd0, vout_a[1]}, 32'hB);
    chk("t2_valid", {31'd0, vout_valid_a[1]}, 32'd1);
    idle_cycle();
    push_exp(1, 4'hB);
    send_bit(1, 1'b1, 1'b1); idle_cycle();
    send_bit(1, 1'b0, 1'b0); idle_cycle();
    send_bit(1, 1'b1, 1'b0); idle_cycle();
    chk("t2g_valid_before_last", {31'd0, vout_valid_a[1]}, 32'd0);
    send_bit(1, 1'b1, 1'b0);
    chk("t2g_valid", {31'd0, vout_valid_a[1]}, 32'd1);
    chk("t2g_vout", {28'd0, vout_a[1]}, 32'hB);
    idle_cycle();

    // Continuous, consumer stalled: 3 then A -> A dropped, overrun
    rdy_a[2] = 1'b0;
    push_exp(2, 4'h3);
    send_word(2, 4'b1100, 1'b1);
    send_word(2, 4'b0101, 1'b0);
    chk("t3_vout_held", {28'd0, vout_a[2]}, 32'h3);
    chk("t3_valid", {31'd0, vout_valid_a[2]}, 32'd1);
    chk("t3_overrun", {31'd0, ov_a[2]}, 32'd1);
    chk("t3_busy_cont", {31'd0, busy_a[2]}, 32'd1);
    chk("t3_no_frame_err", {31'd0, fe_a[2]}, 32'd0);
    rdy_a[2] = 1'b1;
    idle_cycle();
    chk("t3_valid_drop", {31'd0, vout_valid_a[2]}, 32'd0);
    chk("t3_overrun_sticky", {31'd0, ov_a[2]}, 32'd1);
    clr_a[2] = 1'b1;
    idle_cycle();
    clr_a[2] = 1'b0;
    chk("t3_overrun_clr", {31'd0, ov_a[2]}, 32'd0);

    // Continuous back-to-back, 6 completes on the handshake edge of 5
    rdy_a[2] = 1'b0;
    push_exp(2, 4'h5);
    push_exp(2, 4'h6);
    send_word(2, 4'b1010, 1'b1);
    chk("t4_vout5", {28'd0, vout_a[2]}, 32'h5);
    chk("t4_sof_boundary_ok", {31'd0, fe_a[2]}, 32'd0);
    send_bit(2, 1'b0, 1'b0);
    send_bit(2, 1'b1, 1'b0);
    send_bit(2, 1'b1, 1'b0);
    rdy_a[2] = 1'b1;
    send_bit(2, 1'b0, 1'b0);
    chk("t4_valid_no_bubble", {31'd0, vout_valid_a[2]}, 32'd1);
    chk("t4_vout6", {28'd0, vout_a[2]}, 32'h6);
    chk("t4_no_overrun", {31'd0, ov_a[2]}, 32'd0);
    idle_cycle();
    chk("t4_valid_drop", {31'd0, vout_valid_a[2]}, 32'd0);

    // Framing error: sof after two bits, then 1,0,0,1 -> 9
    send_bit(0, 1'b1, 1'b1);
    send_bit(0, 1'b0, 1'b0);
    push_exp(0, 4'h9);
    send_bit(0, 1'b1, 1'b1);
    chk("t5_frame_err", {31'd0, fe_a[0]}, 32'd1);
    chk("t5_no_output", {31'd0, vout_valid_a[0]}, 32'd0);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    chk("t5_vout", {28'd0, vout_a[0]}, 32'h9);
    chk("t5_valid", {31'd0, vout_valid_a[0]}, 32'd1);
    clr_a[0] = 1'b1;
    idle_cycle();
    clr_a[0] = 1'b0;
    chk("t5_fe_clr", {31'd0, fe_a[0]}, 32'd0);
    // Set beats clear on the same edge
    send_bit(0, 1'b1, 1'b1);
    send_bit(0, 1'b0, 1'b0);
    clr_a[0] = 1'b1;
    send_bit(0, 1'b1, 1'b1);
    clr_a[0] = 1'b0;
    chk("t5_set_wins", {31'd0, fe_a[0]}, 32'd1);

    // Reset with a word pending and another in progress
    rdy_a[1] = 1'b0;
    send_word(1, 4'b1111, 1'b1);
    send_bit(1, 1'b1, 1'b1);
    send_bit(1, 1'b0, 1'b0);
    chk("t6_pending", {31'd0, vout_valid_a[1]}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("t6_vout_rst", {28'd0, vout_a[1]}, 32'd0);
    chk("t6_valid_rst", {31'd0, vout_valid_a[1]}, 32'd0);
    chk("t6_busy_rst", {31'd0, busy_a[1]}, 32'd0);
    chk("t6_fe0_rst", {31'd0, fe_a[0]}, 32'd0);
    chk("t6_busy0_rst", {31'd0, busy_a[0]}, 32'd0);
    idle_cycle();
    rst_n = 1'b1;
    rdy_a[1] = 1'b1;
    send_word(1, 4'b1011, 1'b0);
    idle_cycle();
    chk("t6_no_sof_ignored", {31'd0, vout_valid_a[1]}, 32'd0);
    chk("t6_no_sof_idle", {31'd0, busy_a[1]}, 32'd0);

    repeat (2) idle_cycle();
    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    chk("q2_empty", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
